// File: rtl/cmp_seq_ctrl_if.sv
// Operand/result handshake plus the nibble-wide link to the shared 4-bit comparator.
interface cmp_seq_ctrl_if #(parameter int NIBBLES = 4);
  logic                 start;
  logic [4*NIBBLES-1:0] a;
  logic [4*NIBBLES-1:0] b;
  logic [3:0]           ca;
  logic [3:0]           cb;
  logic                 ceq;
  logic                 cgt;
  logic                 clt;
  logic                 busy;
  logic                 done;
  logic                 eq;
  logic                 gt;
  logic                 lt;

  modport slave (
    input  start, a, b, ceq, cgt, clt,
    output ca, cb, busy, done, eq, gt, lt
  );

  modport master (
    output start, a, b, ceq, cgt, clt,
    input  ca, cb, busy, done, eq, gt, lt
  );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// Serial MSB-first nibble compare through one external 4-bit comparator, early exit on mismatch.
// Optional CMP_SIGNED_EN: two's-complement operands, sign mismatch resolved in the first RUN cycle.
module cmp_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic           clk,
  input logic           rst,
  cmp_seq_ctrl_if.slave bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [W-1:0]    a_r, b_r;
  logic [W-1:0]    a_sh, b_sh;
  logic [IDXW-1:0] idx;
  logic            done_r, eq_r, gt_r, lt_r;
  logic            run;
  logic            unused;

  assign run  = (state == RUN);
  assign a_sh = a_r >> {idx, 2'b00};
  assign b_sh = b_r >> {idx, 2'b00};

  assign bus.ca   = run ? a_sh[3:0] : 4'd0;
  assign bus.cb   = run ? b_sh[3:0] : 4'd0;
  assign bus.busy = run;
  assign bus.done = done_r;
  assign bus.eq   = eq_r;
  assign bus.gt   = gt_r;
  assign bus.lt   = lt_r;

  // lt is derived from !ceq & !cgt, so the comparator's own lt is not needed
  assign unused = ^{bus.clt, a_sh, b_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      idx    <= IDX_MAX;
      done_r <= 1'b0;
      eq_r   <= 1'b0;
      gt_r   <= 1'b0;
      lt_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            idx   <= IDX_MAX;
            eq_r  <= 1'b0;
            gt_r  <= 1'b0;
            lt_r  <= 1'b0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
`ifdef CMP_SIGNED_EN
          if (idx == IDX_MAX && a_r[W-1] != b_r[W-1]) begin
            gt_r   <= ~a_r[W-1];
            lt_r   <= a_r[W-1];
            done_r <= 1'b1;
            state  <= DONE;
          end else
`endif
          if (bus.ceq && idx != '0) begin
            idx <= idx - 1'b1;
          end else begin
            if (bus.ceq)      eq_r <= 1'b1;
            else if (bus.cgt) gt_r <= 1'b1;
            else              lt_r <= 1'b1;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Directed bench for cmp_seq_ctrl (NIBBLES=4) driving a behavioural 4-bit comparator on ca/cb.
module tb_cmp_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  cmp_seq_ctrl_if #(.NIBBLES(4)) bus ();

  cmp_seq_ctrl #(.NIBBLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.ceq = (bus.ca == bus.cb);
  assign bus.cgt = (bus.ca >  bus.cb);
  assign bus.clt = (bus.ca <  bus.cb);

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // issue start; returns one tick after the accepting edge (first RUN cycle)
  task automatic go(input logic [15:0] av, input logic [15:0] bv);
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    cyc(); cyc(); cyc();
    checks++;
    if ({bus.busy, bus.done, bus.eq, bus.gt, bus.lt} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt});
    end
    checks++;
    if ({bus.ca, bus.cb} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ca_cb got %h want 00", {bus.ca, bus.cb});
    end
    rst = 1'b0;
    cyc();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_equal();
    int n, nb;
    go(16'h1234, 16'h1234);
    checks++;
    if ({bus.ca, bus.cb} !== 8'h11) begin
      errors++;
      $display("FAIL eq_first_nibble got %h want 11", {bus.ca, bus.cb});
    end
    n = 1; nb = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      if (bus.busy === 1'b1) nb++;
      cyc(); n++;
    end
    checks++;
    if (n != 5 || nb != 4) begin
      errors++;
      $display("FAIL eq_latency got done=%0d busy=%0d want 5 4", n, nb);
    end
    checks++;
    if ({bus.eq, bus.gt, bus.lt, bus.busy} !== 4'b1000) begin
      errors++;
      $display("FAIL eq_result got %b want 1000", {bus.eq, bus.gt, bus.lt, bus.busy});
    end
    cyc();
    checks++;
    if ({bus.done, bus.eq, bus.gt, bus.lt} !== 4'b0100) begin
      errors++;
      $display("FAIL eq_hold got %b want 0100", {bus.done, bus.eq, bus.gt, bus.lt});
    end
  endtask

  task automatic test_lt_mid();
    int n;
    logic [7:0] seq [1:3];
    go(16'h12A4, 16'h12B0);
    checks++;
    if ({bus.eq, bus.gt, bus.lt} !== 3'b000) begin
      errors++;
      $display("FAIL lt_flags_cleared got %b want 000", {bus.eq, bus.gt, bus.lt});
    end
    n = 1;
    while (bus.done !== 1'b1 && n < 20) begin
      if (n <= 3) seq[n] = {bus.ca, bus.cb};
      cyc(); n++;
    end
    checks++;
    if (seq[1] !== 8'h11 || seq[2] !== 8'h22 || seq[3] !== 8'hAB) begin
      errors++;
      $display("FAIL lt_nibbles got %h %h %h want 11 22 ab", seq[1], seq[2], seq[3]);
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL lt_latency got %0d want 4", n);
    end
    checks++;
    if ({bus.eq, bus.gt, bus.lt} !== 3'b001) begin
      errors++;
      $display("FAIL lt_result got %b want 001", {bus.eq, bus.gt, bus.lt});
    end
  endtask

  task automatic test_msb_sign();
    int n;
    logic [2:0] want;
`ifdef CMP_SIGNED_EN
    want = 3'b001;
`else
    want = 3'b010;
`endif
    go(16'h8000, 16'h7FFF);
    n = 1;
    while (bus.done !== 1'b1 && n < 20) begin
      cyc(); n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL msb_latency got %0d want 2", n);
    end
    checks++;
    if ({bus.eq, bus.gt, bus.lt} !== want) begin
      errors++;
      $display("FAIL msb_result got %b want %b", {bus.eq, bus.gt, bus.lt}, want);
    end
  endtask

  task automatic test_start_in_run();
    int n, nd;
    logic [2:0] want;
`ifdef CMP_SIGNED_EN
    want = 3'b001;
`else
    want = 3'b010;
`endif
    // short compare: a start pulse in its only RUN cycle must be dropped
    go(16'hFFFF, 16'h0000);
    bus.a = 16'h0000;
    bus.b = 16'hFFFF;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    checks++;
    if ({bus.done, bus.eq, bus.gt, bus.lt} !== {1'b1, want}) begin
      errors++;
      $display("FAIL ign_short got %b want %b", {bus.done, bus.eq, bus.gt, bus.lt}, {1'b1, want});
    end
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus.done === 1'b1 || bus.busy === 1'b1) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL ign_short_quiet got %0d extra busy/done cycles want 0", nd);
    end
    // long compare: start toggling with other operands through all RUN cycles
    go(16'h5A5A, 16'h5A5A);
    n = 1; nd = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      bus.start = (n != 4);
      bus.a = 16'h0000;
      bus.b = 16'h1111;
      cyc(); n++;
    end
    bus.start = 1'b0;
    checks++;
    if (n != 5 || {bus.eq, bus.gt, bus.lt} !== 3'b100) begin
      errors++;
      $display("FAIL ign_long got n=%0d flags=%b want n=5 flags=100", n, {bus.eq, bus.gt, bus.lt});
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus.done === 1'b1) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL ign_long_single_done got %0d extra done want 0", nd);
    end
  endtask

  task automatic test_reset_abort();
    int n, nd;
    go(16'h1234, 16'h1234);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.ca, bus.cb} !== 13'b0) begin
      errors++;
      $display("FAIL abort_state got %b want all 0",
               {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.ca, bus.cb});
    end
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) nd++;
      cyc();
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d active cycles want 0", nd);
    end
    go(16'h1234, 16'h1234);
    n = 1;
    while (bus.done !== 1'b1 && n < 20) begin
      cyc(); n++;
    end
    checks++;
    if (n != 5 || {bus.eq, bus.gt, bus.lt} !== 3'b100) begin
      errors++;
      $display("FAIL abort_recover got n=%0d flags=%b want n=5 flags=100", n, {bus.eq, bus.gt, bus.lt});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    go(16'h5000, 16'h4000);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_run got done=%b want 0", bus.done);
    end
    cyc();
    checks++;
    if ({bus.done, bus.eq, bus.gt, bus.lt} !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_first_result got %b want 1010", {bus.done, bus.eq, bus.gt, bus.lt});
    end
    // start held in the DONE cycle
    go(16'h1111, 16'h1112);
    checks++;
    if ({bus.busy, bus.done, bus.eq, bus.gt, bus.lt} !== 5'b10000) begin
      errors++;
      $display("FAIL b2b_restart got %b want 10000", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt});
    end
    n = 1;
    while (bus.done !== 1'b1 && n < 20) begin
      cyc(); n++;
    end
    checks++;
    if (n != 5 || {bus.eq, bus.gt, bus.lt} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_second got n=%0d flags=%b want n=5 flags=001", n, {bus.eq, bus.gt, bus.lt});
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_lt_mid();
    test_msb_sign();
    test_start_in_run();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
